rr_push_arbiter: RTL and testbench

- Round-robin arbiter directly upstream of the two-stage FIFO scoreboard chain.
- Merges NREQ requester streams into the single push/data_in interface.
- Never pushes while the FIFO reports full.
- Generates the one-shot start tag marking the single tracked packet the scoreboard follows.

---
 rtl/rr_push_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rr_push_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_push_arbiter.sv
// Round-robin merge of NREQ requester streams into one FIFO push port,
// with a one-shot start tag. Define ARB_STRICT_PRIO0_EN for requester-0 priority.
module rr_push_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int QWID  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_rdy,
    input  logic                  full,
    output logic                  push,
    output logic [WIDTH-1:0]      data_out,
    output logic                  start,
    output logic [QWID-1:0]       grant_id,
    input  logic                  track_en,
    input  logic [QWID-1:0]       track_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SENT  = 2'd2
    } trk_st_e;

    trk_st_e          st_q, st_d;
    logic [QWID-1:0]  trk_id_q, trk_id_d;
    logic [QWID-1:0]  ptr_q, ptr_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [QWID-1:0]  gid_q, gid_d;
    logic             tag_q, tag_d;

    logic             load_en;
    logic             accept;
    logic             gnt_found;
    logic [QWID-1:0]  gnt;
    logic [QWID-1:0]  idx;
    logic [WIDTH-1:0] gnt_data;
    logic             hit_trk;

    assign push     = out_vld_q & ~full;
    assign load_en  = ~out_vld_q | push;
    assign accept   = load_en & gnt_found;
    assign start    = push & tag_q;
    assign data_out = data_q;
    assign grant_id = gid_q;
    assign hit_trk  = (st_q == ST_ARMED) && (gnt == trk_id_q);

    // Descending scan so the candidate closest to ptr wins last.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr_q + QWID'(k);
            if (req_vld[idx]) begin
                gnt       = idx;
                gnt_found = 1'b1;
            end
        end
`ifdef ARB_STRICT_PRIO0_EN
        if (req_vld[0]) begin
            gnt       = '0;
            gnt_found = 1'b1;
        end
`endif
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == QWID'(i)) begin
                gnt_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (accept) begin
            req_rdy[gnt] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
`ifdef ARB_STRICT_PRIO0_EN
            if (gnt != '0) begin
                ptr_d = gnt + QWID'(1);
            end
`else
            ptr_d = gnt + QWID'(1);
`endif
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        data_d    = data_q;
        gid_d     = gid_q;
        tag_d     = tag_q;
        if (accept) begin
            out_vld_d = 1'b1;
            data_d    = gnt_data;
            gid_d     = gnt;
            tag_d     = hit_trk;
        end else if (push) begin
            out_vld_d = 1'b0;
            tag_d     = 1'b0;
        end
    end

    // SENT is terminal: only reset re-arms tracking.
    always_comb begin
        st_d     = st_q;
        trk_id_d = trk_id_q;
        unique case (st_q)
            ST_IDLE: begin
                if (track_en) begin
                    st_d     = ST_ARMED;
                    trk_id_d = track_id;
                end
            end
            ST_ARMED: begin
                if (accept && hit_trk) begin
                    st_d = ST_SENT;
                end
            end
            ST_SENT: begin
                st_d = ST_SENT;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= ST_IDLE;
            trk_id_q  <= '0;
            ptr_q     <= '0;
            out_vld_q <= 1'b0;
            data_q    <= '0;
            gid_q     <= '0;
            tag_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            trk_id_q  <= trk_id_d;
            ptr_q     <= ptr_d;
            out_vld_q <= out_vld_d;
            data_q    <= data_d;
            gid_q     <= gid_d;
            tag_q     <= tag_d;
        end
    end

endmodule

// File: tb/tb_rr_push_arbiter.sv
// Randomized bench for rr_push_arbiter with a queue-based packet model.
// Builds with or without ARB_STRICT_PRIO0_EN.
module tb_rr_push_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_vld = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_rdy;
    logic        full = 1'b0;
    logic        push;
    logic [7:0]  data_out;
    logic        start;
    logic [1:0]  grant_id;
    logic        track_en = 1'b0;
    logic [1:0]  track_id = '0;

    rr_push_arbiter #(.WIDTH(W), .NREQ(N), .QWID(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .full     (full),
        .push     (push),
        .data_out (data_out),
        .start    (start),
        .grant_id (grant_id),
        .track_en (track_en),
        .track_id (track_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        int         id;
        bit         tag;
    } pkt_t;

    pkt_t mq[$];
    int   m_ptr;
    int   m_st;
    int   m_trk;

    int vectors;
    int miscompares;

    logic       obs_push;
    logic       obs_start;
    logic [3:0] obs_rdy;
    logic [7:0] obs_d;
    logic [1:0] obs_gid;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
`ifdef ARB_STRICT_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ptr = 0;
        m_st  = 0;
        m_trk = 0;
    endtask

    // Apply inputs, compare at negedge, advance model, return at posedge+1.
    task automatic step(input logic [3:0] v, input logic [31:0] d,
                        input logic f, input logic te,
                        input logic [1:0] tid);
        bit   pe;
        bit   ld;
        bit   acc;
        int   g;
        pkt_t p;
        req_vld  = v;
        req_data = d;
        full     = f;
        track_en = te;
        track_id = tid;
        @(negedge clk);
        pe  = (mq.size() != 0) && !f;
        ld  = (mq.size() == 0) || pe;
        g   = pick(v, m_ptr);
        acc = ld && (g >= 0);
        obs_push  = push;
        obs_start = start;
        obs_rdy   = req_rdy;
        obs_d     = data_out;
        obs_gid   = grant_id;
        chk("push", {31'b0, push}, {31'b0, pe});
        chk("req_rdy", {28'b0, req_rdy}, acc ? (32'd1 << g) : 32'd0);
        chk("start", {31'b0, start},
            {31'b0, (pe && mq.size() != 0 && mq[0].tag)});
        if (mq.size() != 0) begin
            chk("data_out", {24'b0, data_out}, {24'b0, mq[0].d});
            chk("grant_id", {30'b0, grant_id}, mq[0].id);
        end
        if (pe) mq.delete(0);
        if (acc) begin
            p.d   = d[g*8 +: 8];
            p.id  = g;
            p.tag = (m_st == 1) && (g == m_trk);
            mq.push_back(p);
`ifdef ARB_STRICT_PRIO0_EN
            if (g != 0) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
        end
        if (m_st == 0 && te) begin
            m_st  = 1;
            m_trk = tid;
        end else if (m_st == 1 && acc && g == m_trk) begin
            m_st = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_push", {31'b0, push}, 0);
        chk("rst_start", {31'b0, start}, 0);
        chk("rst_data", {24'b0, data_out}, 0);
        chk("rst_gid", {30'b0, grant_id}, 0);
        model_reset();
        req_vld  = '0;
        track_en = 1'b0;
        full     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int         nacc;
        int         nst;
`ifdef ARB_STRICT_PRIO0_EN
        int t1_exp[5] = '{0, 0, 0, 0, 0};
        int t5_exp[7] = '{0, 0, 0, 1, 2, 3, 1};
`else
        int t1_exp[5] = '{0, 1, 2, 3, 0};
`endif
        vectors     = 0;
        miscompares = 0;
        model_reset();
        #2;
        do_reset();

        // All requesters streaming, no backpressure
        for (int c = 0; c < 6; c++) begin
            step(4'hF, 32'h44332211, 1'b0, 1'b0, 2'd0);
            if (c >= 1) begin
                chk("t1_push", {31'b0, obs_push}, 1);
                chk("t1_gid", {30'b0, obs_gid}, t1_exp[c-1]);
            end
        end

        // Single requester held off by full
        do_reset();
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            step(4'b0100, 32'h00A50000, 1'b1, 1'b0, 2'd0);
            nacc += int'(obs_rdy[2]);
            chk("t2_push_full", {31'b0, obs_push}, 0);
        end
        chk("t2_accepts", nacc, 1);
        step(4'b0000, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t2_push", {31'b0, obs_push}, 1);
        chk("t2_data", {24'b0, obs_d}, 32'hA5);
        chk("t2_gid", {30'b0, obs_gid}, 2);
        step(4'b0000, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t2_nopush", {31'b0, obs_push}, 0);

        // One-shot tracking of requester 1
        do_reset();
        nst = 0;
        for (int c = 0; c < 14; c++) begin
            step(4'b1110, 32'h44332211, 1'b0, (c == 0 || c == 8),
                 (c == 8) ? 2'd3 : 2'd1);
            if (obs_start) begin
                nst++;
                chk("t3_start_cycle", c, 4);
                chk("t3_start_gid", {30'b0, obs_gid}, 1);
            end
        end
        chk("t3_nstart", nst, 1);

        // Reset while a packet is in flight and tracking is armed
        do_reset();
        step(4'b0001, 32'h0000005C, 1'b0, 1'b1, 2'd3);
        req_vld = '0;
        full    = 1'b0;
        #1;
        chk("t4_push_pre", {31'b0, push}, 1);
        chk("t4_data_pre", {24'b0, data_out}, 32'h5C);
        do_reset();
        step(4'hF, 32'h44332211, 1'b0, 1'b0, 2'd0);
        chk("t4_first_gnt", {28'b0, obs_rdy}, 32'h1);
        step(4'b1000, 32'h44332211, 1'b0, 1'b0, 2'd0);
        step(4'b0000, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t4_push3", {31'b0, obs_push}, 1);
        chk("t4_gid3", {30'b0, obs_gid}, 3);
        chk("t4_nostart", {31'b0, obs_start}, 0);

`ifdef ARB_STRICT_PRIO0_EN
        // Strict priority for requester 0
        do_reset();
        for (int c = 0; c < 7; c++) begin
            step((c < 3) ? 4'hF : 4'hE, 32'h44332211, 1'b0, 1'b0, 2'd0);
            chk("t5_gnt", {28'b0, obs_rdy}, 32'd1 << t5_exp[c]);
        end
`endif

        // Random traffic, backpressure and occasional tracking
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if (i % 2500 == 2499) do_reset();
            step(4'($urandom), $urandom, ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 199) == 0), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
